// File: rtl/ioctl_rom_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_rom_streamer
// Description : Transmit side of the ioctl download interface. Converts a
//               valid/ready byte stream into ioctl_download / ioctl_wr /
//               ioctl_addr / ioctl_dout / ioctl_index traffic for a ROM
//               loader, honouring ioctl_wait back-pressure.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset_n          : clock and asynchronous active-low reset
//   start, abort            : transfer request / terminate request
//   base_addr, length       : first address and byte count (0 = empty)
//   index_in                : ioctl_index value for the transfer
//   s_data/s_valid/s_ready  : byte source handshake
//   ioctl_*                 : download interface towards the core
//   busy, done, aborted     : transfer status
// ============================================================================
module ioctl_rom_streamer #(
  parameter int ADDR_W  = 25,
  parameter int WR_HOLD = 2,
  parameter int WR_GAP  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [7:0]        index_in,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CNT_MAX = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_FETCH  = 3'd2,
    S_STROBE = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   remaining, remaining_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [7:0]          dout_nxt;
  logic [7:0]          index_nxt;
  logic                download_nxt;
  logic                wr_nxt;
  logic                done_nxt;
  logic                aborted_nxt;
  logic                abort_hit;
  logic                accept;

  // Abort only matters while a transfer is actually in progress.
  assign abort_hit = abort && (state != S_IDLE) && (state != S_FINISH);

  // Ready is suppressed by a pending abort so the source never believes a
  // byte was taken that the streamer is about to throw away.
  assign s_ready = (state == S_FETCH) && !ioctl_wait && !abort;
  assign accept  = s_ready && s_valid;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    remaining_nxt = remaining;
    addr_nxt      = ioctl_addr;
    dout_nxt      = ioctl_dout;
    index_nxt     = ioctl_index;
    download_nxt  = ioctl_download;
    wr_nxt        = ioctl_wr;
    done_nxt      = 1'b0;
    aborted_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_nxt     = S_ARM;
            remaining_nxt = length;
            addr_nxt      = base_addr;
            index_nxt     = index_in;
            download_nxt  = 1'b1;
          end else begin
            // Empty transfer: report completion without touching download.
            state_nxt = S_FINISH;
            done_nxt  = 1'b1;
          end
        end
      end

      S_ARM: begin
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        if (accept) begin
          state_nxt = S_STROBE;
          dout_nxt  = s_data;
          wr_nxt    = 1'b1;
          cnt_nxt   = '0;
        end
      end

      S_STROBE: begin
        if (cnt == CNT_W'(WR_HOLD - 1)) begin
          state_nxt = S_GAP;
          wr_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        // Count saturates at the minimum gap; afterwards only ioctl_wait
        // keeps us here.
        if (cnt != CNT_W'(WR_GAP - 1)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else if (!ioctl_wait) begin
          remaining_nxt = remaining - ADDR_W'(1);
          addr_nxt      = ioctl_addr + ADDR_W'(1);
          if (remaining == ADDR_W'(1)) begin
            state_nxt    = S_FINISH;
            download_nxt = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end

      S_FINISH: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt    = S_IDLE;
        wr_nxt       = 1'b0;
        download_nxt = 1'b0;
      end
    endcase

    // Abort overrides whatever the state decided this cycle: strobe is cut,
    // address/count are left as they were.
    if (abort_hit) begin
      state_nxt     = S_FINISH;
      cnt_nxt       = cnt;
      remaining_nxt = remaining;
      addr_nxt      = ioctl_addr;
      dout_nxt      = ioctl_dout;
      index_nxt     = ioctl_index;
      download_nxt  = 1'b0;
      wr_nxt        = 1'b0;
      done_nxt      = 1'b1;
      aborted_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      remaining      <= '0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      ioctl_index    <= '0;
      ioctl_download <= 1'b0;
      ioctl_wr       <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      remaining      <= remaining_nxt;
      ioctl_addr     <= addr_nxt;
      ioctl_dout     <= dout_nxt;
      ioctl_index    <= index_nxt;
      ioctl_download <= download_nxt;
      ioctl_wr       <= wr_nxt;
      done           <= done_nxt;
      aborted        <= aborted_nxt;
      busy           <= (state_nxt != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ioctl_rom_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioctl_rom_streamer
// Description : Directed self-checking bench for ioctl_rom_streamer.
//               A negedge monitor records every write pulse (address, data,
//               rise cycle, width) and status counters; directed tests
//               compare these against hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_rom_streamer;

  localparam int ADDR_W = 25;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic [7:0]        index_in;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              busy;
  logic              done;
  logic              aborted;

  ioctl_rom_streamer #(.ADDR_W(ADDR_W), .WR_HOLD(2), .WR_GAP(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .length         (length),
    .index_in       (index_in),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Source: byte n of the stream is 0xA0 + n.
  int   src_idx = 0;
  logic valid_drv;
  logic rand_mode;
  logic rnd_valid = 1'b0;

  assign s_data  = 8'(8'hA0 + src_idx);
  assign s_valid = rand_mode ? rnd_valid : valid_drv;

  always @(posedge clock) if (s_valid && s_ready) src_idx <= src_idx + 1;
  always @(negedge clock) rnd_valid <= 1'($urandom_range(0, 1));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor
  logic [ADDR_W-1:0] rise_addr [$];
  logic [7:0]        rise_dout [$];
  int                rise_cyc  [$];
  int                hold_len  [$];
  logic              wr_prev = 1'b0;
  logic [ADDR_W-1:0] cur_addr = '0;
  int hold_cnt = 0, addr_viol = 0, dl_cycles = 0, rdy_cycles = 0;
  int rdy_wait_viol = 0, done_cnt = 0, abort_cnt = 0;

  always @(negedge clock) begin
    if (ioctl_wr && !wr_prev) begin
      rise_addr.push_back(ioctl_addr);
      rise_dout.push_back(ioctl_dout);
      rise_cyc.push_back(cyc);
      hold_cnt <= 1;
      cur_addr <= ioctl_addr;
    end else if (ioctl_wr) begin
      hold_cnt <= hold_cnt + 1;
      if (ioctl_addr != cur_addr) addr_viol <= addr_viol + 1;
    end else if (wr_prev) begin
      hold_len.push_back(hold_cnt);
    end
    if (ioctl_download)       dl_cycles     <= dl_cycles + 1;
    if (s_ready)              rdy_cycles    <= rdy_cycles + 1;
    if (s_ready && ioctl_wait) rdy_wait_viol <= rdy_wait_viol + 1;
    if (done)                 done_cnt      <= done_cnt + 1;
    if (done && aborted)      abort_cnt     <= abort_cnt + 1;
    wr_prev <= ioctl_wr;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int t_start, idx0, ro, ho, dl0, rdy0, done0, ab0;

  task automatic snap();
    ro    = rise_addr.size();
    ho    = hold_len.size();
    dl0   = dl_cycles;
    rdy0  = rdy_cycles;
    done0 = done_cnt;
    ab0   = abort_cnt;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                          input logic [7:0] ix);
    @(posedge clock); #1;
    snap();
    idx0      = src_idx;
    base_addr = b;
    length    = l;
    index_in  = ix;
    start     = 1'b1;
    t_start   = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clock);
      k++;
    end
    check(tag, 32'(done), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic wait_wr(input logic level, input int limit);
    int k = 0;
    while (ioctl_wr !== level && k < limit) begin
      @(negedge clock);
      k++;
    end
    check("wr_reach", 32'(ioctl_wr), 32'(level));
  endtask

  task automatic check_pulses(input string tag, input int n, input logic [ADDR_W-1:0] b);
    check({tag, "_npulses"}, 32'(rise_addr.size() - ro), 32'(n));
    for (int k = 0; k < n && (ro + k) < rise_addr.size(); k++) begin
      logic [ADDR_W-1:0] ea;
      logic [7:0]        ed;
      ea = ADDR_W'(b + ADDR_W'(k));
      ed = 8'(8'hA0 + idx0 + k);
      check({tag, "_addr"}, 32'(rise_addr[ro + k]), 32'(ea));
      check({tag, "_dout"}, 32'(rise_dout[ro + k]), 32'(ed));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    base_addr  = '0;
    length     = '0;
    index_in   = '0;
    valid_drv  = 1'b1;
    rand_mode  = 1'b0;
    ioctl_wait = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_wr",       32'(ioctl_wr),       32'd0);
    check("rst_download", 32'(ioctl_download), 32'd0);
    check("rst_addr",     32'(ioctl_addr),     32'd0);
    check("rst_dout",     32'(ioctl_dout),     32'd0);
    check("rst_index",    32'(ioctl_index),    32'd0);
    check("rst_busy",     32'(busy),           32'd0);
    check("rst_done",     32'(done),           32'd0);
    check("rst_sready",   32'(s_ready),        32'd0);
    reset_n = 1'b1;

    // 1: basic four-byte transfer
    do_start(25'h100, 25'd4, 8'h05);
    check("t1_download_arm", 32'(ioctl_download), 32'd1);
    check("t1_index",        32'(ioctl_index),    32'h05);
    wait_done("t1_done", 200);
    check_pulses("t1", 4, 25'h100);
    for (int k = 0; k < 4 && (ho + k) < hold_len.size(); k++)
      check("t1_hold", 32'(hold_len[ho + k]), 32'd2);
    if (rise_cyc.size() >= ro + 4) begin
      check("t1_first_rise", 32'(rise_cyc[ro] - t_start), 32'd3);
      for (int k = 1; k < 4; k++)
        check("t1_spacing", 32'(rise_cyc[ro + k] - rise_cyc[ro + k - 1]), 32'd5);
    end
    check("t1_dl_cycles", 32'(dl_cycles - dl0), 32'd21);
    check("t1_done_cnt",  32'(done_cnt - done0), 32'd1);
    check("t1_abort_cnt", 32'(abort_cnt - ab0),  32'd0);
    check("t1_done_low",  32'(done),             32'd0);
    check("t1_dl_low",    32'(ioctl_download),   32'd0);

    // 2: empty transfer
    do_start(25'h040, 25'd0, 8'h11);
    check("t2_done_next", 32'(done), 32'd1);
    check("t2_aborted",   32'(aborted), 32'd0);
    wait_done("t2_done", 10);
    check("t2_done_pulse", 32'(done), 32'd0);
    check("t2_no_dl",  32'(dl_cycles - dl0),         32'd0);
    check("t2_no_wr",  32'(rise_addr.size() - ro),   32'd0);
    check("t2_no_rdy", 32'(rdy_cycles - rdy0),       32'd0);

    // 3: ioctl_wait during the gap after byte 1 delays byte 2 by 10 cycles
    do_start(25'h010, 25'd3, 8'h22);
    wait_wr(1'b1, 50);
    wait_wr(1'b0, 50);
    @(negedge clock);
    ioctl_wait = 1'b1;
    repeat (10) @(negedge clock);
    ioctl_wait = 1'b0;
    wait_done("t3_done", 200);
    check_pulses("t3", 3, 25'h010);
    if (rise_cyc.size() >= ro + 3) begin
      check("t3_delay",  32'(rise_cyc[ro + 1] - rise_cyc[ro]),     32'd15);
      check("t3_normal", 32'(rise_cyc[ro + 2] - rise_cyc[ro + 1]), 32'd5);
    end
    check("t3_rdy_wait", 32'(rdy_wait_viol), 32'd0);

    // 4: address wrap
    do_start(25'h1FFFFFF, 25'd2, 8'h33);
    wait_done("t4_done", 100);
    check_pulses("t4", 2, 25'h1FFFFFF);

    // 5: abort in the strobe of byte 3 of 8
    do_start(25'h080, 25'd8, 8'h44);
    wait_wr(1'b1, 50);
    wait_wr(1'b0, 50);
    wait_wr(1'b1, 50);
    wait_wr(1'b0, 50);
    wait_wr(1'b1, 50);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("t5_wr_cut",   32'(ioctl_wr),       32'd0);
    check("t5_done",     32'(done),           32'd1);
    check("t5_aborted",  32'(aborted),        32'd1);
    check("t5_dl_low",   32'(ioctl_download), 32'd0);
    @(negedge clock);
    check("t5_idle",     32'(busy),           32'd0);
    check("t5_done_end", 32'(done),           32'd0);
    check_pulses("t5", 3, 25'h080);
    if (hold_len.size() >= ho + 3)
      check("t5_cut_hold", 32'(hold_len[ho + 2]), 32'd1);
    do_start(25'h200, 25'd2, 8'h55);
    wait_done("t5r_done", 100);
    check_pulses("t5r", 2, 25'h200);
    check("t5r_abort_cnt", 32'(abort_cnt - ab0), 32'd0);

    // 6: random source, start while busy, reset mid-transfer
    rand_mode = 1'b1;
    do_start(25'h300, 25'd6, 8'h66);
    wait_wr(1'b1, 200);
    base_addr = 25'h999;
    length    = 25'd3;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("t6_done", 2000);
    check_pulses("t6", 6, 25'h300);
    check("t6_done_cnt", 32'(done_cnt - done0), 32'd1);
    rand_mode = 1'b0;

    do_start(25'h400, 25'd8, 8'h77);
    wait_wr(1'b1, 50);
    wait_wr(1'b0, 50);
    wait_wr(1'b1, 50);
    reset_n = 1'b0;
    #1;
    check("t6r_wr",       32'(ioctl_wr),       32'd0);
    check("t6r_download", 32'(ioctl_download), 32'd0);
    check("t6r_addr",     32'(ioctl_addr),     32'd0);
    check("t6r_dout",     32'(ioctl_dout),     32'd0);
    check("t6r_index",    32'(ioctl_index),    32'd0);
    check("t6r_busy",     32'(busy),           32'd0);
    check("t6r_sready",   32'(s_ready),        32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("t6r_idle",     32'(busy),           32'd0);
    check("t6r_dl_idle",  32'(ioctl_download), 32'd0);
    do_start(25'h005, 25'd1, 8'h88);
    wait_done("t6p_done", 100);
    check_pulses("t6p", 1, 25'h005);
    check("t6p_index", 32'(ioctl_index), 32'h88);

    check("addr_stable", 32'(addr_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
